// File: rtl/snitch_perf_sampler.sv
// -----------------------------------------------------------------------------
// snitch_perf_sampler
//
// Periodically reads a selectable set of 48-bit cluster performance counters
// over the peripheral register port and queues each result as a tagged sample
// for a trace/DMA consumer.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   enable_i            sampling enable (low clears the tick timer)
//   period_i            tick period in cycles (0 = tick every cycle)
//   counter_mask_i      counters read on each tick
//   reg_req_o           read requests (registered, held until ready)
//   reg_rsp_i           register responses
//   sample_valid_o      sample FIFO non-empty
//   sample_ready_i      consumer accepts head sample
//   sample_value_o      head sample value (rdata[47:0])
//   sample_idx_o        head sample counter index
//   sample_err_o        head sample response error flag
//   busy_o              a scan is in progress
//   overrun_cnt_o       saturating count of ticks dropped during a scan
// -----------------------------------------------------------------------------

package snitch_perf_sampler_pkg;

    localparam int unsigned RegAddrWidth = 48;
    localparam int unsigned RegDataWidth = 64;

    typedef struct packed {
        logic [RegAddrWidth-1:0]   addr;
        logic                      write;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
        logic                      valid;
    } reg_req_t;

    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_rsp_t;

endpackage

module snitch_perf_sampler
    import snitch_perf_sampler_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          NumCounters   = 16,
    parameter logic [AddrWidth-1:0] BaseAddr      = {AddrWidth{1'b0}},
    parameter int unsigned          CounterStride = 8,
    parameter int unsigned          FifoDepth     = 4,
    localparam int unsigned         IdxW          = $clog2(NumCounters)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [31:0]            period_i,
    input  logic [NumCounters-1:0] counter_mask_i,
    output reg_req_t               reg_req_o,
    input  reg_rsp_t               reg_rsp_i,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic [47:0]            sample_value_o,
    output logic [IdxW-1:0]        sample_idx_o,
    output logic                   sample_err_o,
    output logic                   busy_o,
    output logic [15:0]            overrun_cnt_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrOne  = {{(PtrW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StReq  = 2'd2;

    typedef struct packed {
        logic [47:0]     value;
        logic [IdxW-1:0] idx;
        logic            err;
    } sample_t;

    localparam int unsigned EntryW = $bits(sample_t);

    // Lowest set bit of the pending vector; the scan walks counters upwards.
    function automatic logic [IdxW-1:0] lowest_set(input logic [NumCounters-1:0] vec);
        logic [IdxW-1:0] res;
        res = {IdxW{1'b0}};
        for (int i = NumCounters - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = IdxW'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Register address of a counter slot, wrapping at AddrWidth bits.
    function automatic logic [AddrWidth-1:0] counter_addr(input logic [IdxW-1:0] idx);
        return BaseAddr + (AddrWidth'(idx) * AddrWidth'(CounterStride));
    endfunction

    logic [31:0]            timer_r;
    logic                   tick_s;
    logic [1:0]             state_r;
    logic [1:0]             state_next_s;
    logic [NumCounters-1:0] pending_r;
    logic [NumCounters-1:0] pending_next_s;
    logic [IdxW-1:0]        idx_r;
    logic [IdxW-1:0]        idx_next_s;
    logic                   req_valid_r;
    logic                   req_valid_next_s;
    logic [AddrWidth-1:0]   req_addr_r;
    logic [AddrWidth-1:0]   req_addr_next_s;
    logic                   push_s;
    logic                   push_ok_s;
    logic                   pop_s;
    logic                   full_s;
    sample_t                fifo_mem_r [FifoDepth];
    logic [PtrW-1:0]        wr_ptr_r;
    logic [PtrW-1:0]        rd_ptr_r;
    logic [CntW-1:0]        count_r;
    logic [CntW-1:0]        count_next_s;
    logic [15:0]            overrun_r;
    logic                   busy_r;
    logic                   sample_valid_r;
    sample_t                push_entry_s;
    logic                   unused_rdata_s;

    // Only the low 48 bits of a counter are meaningful.
    assign unused_rdata_s = ^reg_rsp_i.rdata[RegDataWidth-1:48];

    assign tick_s    = enable_i && (timer_r == 32'd0);
    assign full_s    = (count_r == CntFull);
    assign pop_s     = sample_valid_r && sample_ready_i;
    // Entering REQ requires a free slot, so a push never meets a full FIFO
    // unless the head is leaving in the same cycle.
    assign push_ok_s = push_s && (!full_s || pop_s);

    assign push_entry_s = '{value: reg_rsp_i.rdata[47:0], idx: idx_r, err: reg_rsp_i.error};

    // Tick timer: reloads period-1 on each tick, held at zero while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_r <= 32'd0;
        end else if (!enable_i) begin
            timer_r <= 32'd0;
        end else if (timer_r == 32'd0) begin
            timer_r <= (period_i == 32'd0) ? 32'd0 : (period_i - 32'd1);
        end else begin
            timer_r <= timer_r - 32'd1;
        end
    end

    // Scan FSM next-state and request-register next values.
    always_comb begin
        state_next_s     = state_r;
        pending_next_s   = pending_r;
        idx_next_s       = idx_r;
        req_valid_next_s = 1'b0;
        req_addr_next_s  = req_addr_r;
        push_s           = 1'b0;
        case (state_r)
            StIdle: begin
                if (tick_s) begin
                    pending_next_s = counter_mask_i;
                    state_next_s   = StScan;
                end else begin
                    state_next_s   = StIdle;
                end
            end
            StScan: begin
                if (!enable_i || (pending_r == {NumCounters{1'b0}})) begin
                    state_next_s = StIdle;
                end else begin
                    idx_next_s = lowest_set(pending_r);
                    if (!full_s) begin
                        state_next_s     = StReq;
                        req_valid_next_s = 1'b1;
                        req_addr_next_s  = counter_addr(idx_next_s);
                    end else begin
                        state_next_s     = StScan;
                    end
                end
            end
            StReq: begin
                if (reg_rsp_i.ready) begin
                    push_s                = 1'b1;
                    pending_next_s[idx_r] = 1'b0;
                    // Disable abandons the remaining pending bits once the
                    // outstanding read has landed.
                    state_next_s          = enable_i ? StScan : StIdle;
                end else begin
                    req_valid_next_s      = 1'b1;
                    state_next_s          = StReq;
                end
            end
            default: begin
                state_next_s   = StIdle;
                pending_next_s = {NumCounters{1'b0}};
            end
        endcase
    end

    // Scan FSM state, request registers and busy flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= StIdle;
            pending_r   <= {NumCounters{1'b0}};
            idx_r       <= {IdxW{1'b0}};
            req_valid_r <= 1'b0;
            req_addr_r  <= {AddrWidth{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pending_r   <= pending_next_s;
            idx_r       <= idx_next_s;
            req_valid_r <= req_valid_next_s;
            req_addr_r  <= req_addr_next_s;
            busy_r      <= (state_next_s != StIdle);
        end
    end

    // Overrun counter: any tick that arrives while a scan is active is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_r <= 16'h0000;
        end else if (tick_s && (state_r != StIdle) && (overrun_r != 16'hFFFF)) begin
            overrun_r <= overrun_r + 16'h0001;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // FIFO occupancy next value.
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s && !pop_s) begin
            count_next_s = count_r + CntOne;
        end else if (!push_ok_s && pop_s) begin
            count_next_s = count_r - CntOne;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage, pointers, occupancy and registered non-empty flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_mem_r[i] <= {EntryW{1'b0}};
            end
            wr_ptr_r       <= {PtrW{1'b0}};
            rd_ptr_r       <= {PtrW{1'b0}};
            count_r        <= {CntW{1'b0}};
            sample_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r             <= wr_ptr_r + PtrOne;
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrOne;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r        <= count_next_s;
            sample_valid_r <= (count_next_s != {CntW{1'b0}});
        end
    end

    assign reg_req_o = '{
        addr:  RegAddrWidth'(req_addr_r),
        write: 1'b0,
        wdata: {RegDataWidth{1'b0}},
        wstrb: {(RegDataWidth/8){1'b0}},
        valid: req_valid_r
    };

    assign sample_valid_o = sample_valid_r;
    assign sample_value_o = fifo_mem_r[rd_ptr_r].value;
    assign sample_idx_o   = fifo_mem_r[rd_ptr_r].idx;
    assign sample_err_o   = fifo_mem_r[rd_ptr_r].err;
    assign busy_o         = busy_r;
    assign overrun_cnt_o  = overrun_r;

endmodule

// File: tb/tb_snitch_perf_sampler.sv
// -----------------------------------------------------------------------------
// tb_snitch_perf_sampler
//
// Directed bench for snitch_perf_sampler: a configurable register responder
// (latency, stall, error index), a monitor logging handshakes and popped
// samples, and a sequence of scenarios with hand-derived expectations.
// -----------------------------------------------------------------------------

module tb_snitch_perf_sampler;
    import snitch_perf_sampler_pkg::*;

    localparam int unsigned IdxW = 4;
    localparam logic [47:0] Base = 48'h1000;

    logic        clk_i;
    logic        rst_i;
    logic        enable_i;
    logic [31:0] period_i;
    logic [15:0] counter_mask_i;
    reg_req_t    reg_req_o;
    reg_rsp_t    reg_rsp_i = '0;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [47:0] sample_value_o;
    logic [IdxW-1:0] sample_idx_o;
    logic        sample_err_o;
    logic        busy_o;
    logic [15:0] overrun_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // responder configuration (written by the sequence, read by the responder)
    int          rsp_lat     = 0;
    logic        rsp_stall   = 1'b0;
    logic [63:0] rsp_rdata   = 64'd0;
    int          rsp_err_idx = 99;
    int          rsp_wait    = 0;

    // monitor state
    int          cyc        = 0;
    logic        prev_valid = 1'b0;
    logic [47:0] req_addr_q [$];
    int          rise_q     [$];
    logic [52:0] smp_q      [$];

    int en_cyc;

    snitch_perf_sampler #(
        .BaseAddr (48'h1000)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .period_i       (period_i),
        .counter_mask_i (counter_mask_i),
        .reg_req_o      (reg_req_o),
        .reg_rsp_i      (reg_rsp_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_value_o (sample_value_o),
        .sample_idx_o   (sample_idx_o),
        .sample_err_o   (sample_err_o),
        .busy_o         (busy_o),
        .overrun_cnt_o  (overrun_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Responder: decides ready shortly after each rising edge so it is stable
    // for the whole following cycle.
    always @(posedge clk_i) begin
        #1;
        if (reg_req_o.valid && !rsp_stall && (rsp_wait >= rsp_lat)) begin
            reg_rsp_i.ready = 1'b1;
            reg_rsp_i.rdata = rsp_rdata;
            reg_rsp_i.error = (int'((reg_req_o.addr - Base) >> 3) == rsp_err_idx);
            rsp_wait        = 0;
        end else begin
            reg_rsp_i.ready = 1'b0;
            reg_rsp_i.rdata = 64'd0;
            reg_rsp_i.error = 1'b0;
            if (!reg_req_o.valid) begin
                rsp_wait = 0;
            end else if (!rsp_stall) begin
                rsp_wait = rsp_wait + 1;
            end
        end
    end

    // Monitor: logs completed reads, request rising edges and popped samples.
    always @(posedge clk_i) begin
        if (rst_i) begin
            req_addr_q.delete();
            rise_q.delete();
            smp_q.delete();
        end else begin
            if (reg_req_o.valid && reg_rsp_i.ready) req_addr_q.push_back(reg_req_o.addr);
            if (reg_req_o.valid && !prev_valid) rise_q.push_back(cyc);
            if (sample_valid_o && sample_ready_i)
                smp_q.push_back({sample_value_o, sample_idx_o, sample_err_o});
        end
        prev_valid = reg_req_o.valid;
        cyc        = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        enable_i       = 1'b0;
        sample_ready_i = 1'b0;
        period_i       = 32'd0;
        counter_mask_i = 16'd0;
        rsp_stall      = 1'b0;
        rsp_lat        = 0;
        rsp_err_idx    = 99;
        rsp_rdata      = 64'd0;
        step(3);
        rst_i = 1'b0;
        step(1);
    endtask

    function automatic logic [47:0] q_addr(input int i);
        return (i < req_addr_q.size()) ? req_addr_q[i] : 48'hDEAD_DEAD_DEAD;
    endfunction

    function automatic logic [52:0] q_smp(input int i);
        return (i < smp_q.size()) ? smp_q[i] : {53{1'b1}};
    endfunction

    function automatic int q_rise(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -1000;
    endfunction

    initial begin
        do_reset();

        // ---- reset values ----
        check_eq("rst_req_valid", 64'(reg_req_o.valid), 64'd0);
        check_eq("rst_req_addr",  64'(reg_req_o.addr),  64'd0);
        check_eq("rst_smp_valid", 64'(sample_valid_o),  64'd0);
        check_eq("rst_smp_value", 64'(sample_value_o),  64'd0);
        check_eq("rst_smp_idx",   64'(sample_idx_o),    64'd0);
        check_eq("rst_smp_err",   64'(sample_err_o),    64'd0);
        check_eq("rst_busy",      64'(busy_o),          64'd0);
        check_eq("rst_overrun",   64'(overrun_cnt_o),   64'd0);

        // ---- basic scan: mask 0b0101, latency 2, period 100 ----
        period_i       = 32'd100;
        counter_mask_i = 16'h0005;
        rsp_lat        = 2;
        rsp_rdata      = 64'hFFFF_1234_5678_9ABC;
        sample_ready_i = 1'b1;
        enable_i       = 1'b1;
        en_cyc         = cyc;
        step(1);
        check_eq("basic_busy_scan", 64'(busy_o), 64'd1);
        check_eq("basic_valid_t1",  64'(reg_req_o.valid), 64'd0);
        step(1);
        check_eq("basic_valid_t2",  64'(reg_req_o.valid), 64'd1);
        check_eq("basic_addr0",     64'(reg_req_o.addr),  64'h1000);
        check_eq("basic_write",     64'(reg_req_o.write), 64'd0);
        step(100);
        sample_ready_i = 1'b0;
        step(4);
        check_eq("basic_rd0_addr",  64'(q_addr(0)), 64'h1000);
        check_eq("basic_rd1_addr",  64'(q_addr(1)), 64'h1010);
        check_eq("basic_smp_cnt",   64'(smp_q.size()), 64'd2);
        check_eq("basic_smp0",      64'(q_smp(0)), 64'({48'h1234_5678_9ABC, 4'd0, 1'b0}));
        check_eq("basic_smp1",      64'(q_smp(1)), 64'({48'h1234_5678_9ABC, 4'd2, 1'b0}));
        check_eq("basic_first_lat", 64'(q_rise(0) - en_cyc), 64'd2);
        check_eq("basic_req_gap",   64'(q_rise(1) - q_rise(0)), 64'd4);
        check_eq("basic_period",    64'(q_rise(2) - q_rise(0)), 64'd100);
        check_eq("basic_overrun",   64'(overrun_cnt_o), 64'd0);

        // ---- asynchronous reset while a request is outstanding ----
        check_eq("mid_req_valid",   64'(reg_req_o.valid), 64'd1);
        check_eq("mid_req_addr",    64'(reg_req_o.addr),  64'h1010);
        check_eq("mid_fifo_nonempty", 64'(sample_valid_o), 64'd1);
        #1;
        rst_i    = 1'b1;
        enable_i = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(reg_req_o.valid), 64'd0);
        check_eq("async_rst_smpv",  64'(sample_valid_o),  64'd0);
        step(2);
        rst_i = 1'b0;
        step(1);
        check_eq("post_rst_valid",  64'(reg_req_o.valid), 64'd0);
        check_eq("post_rst_smpv",   64'(sample_valid_o),  64'd0);
        check_eq("post_rst_busy",   64'(busy_o),          64'd0);
        check_eq("post_rst_value",  64'(sample_value_o),  64'd0);
        check_eq("post_rst_overrun",64'(overrun_cnt_o),   64'd0);

        // ---- backpressure: FIFO of 4 fills, consumer stalled ----
        do_reset();
        period_i       = 32'd1000;
        counter_mask_i = 16'hFFFF;
        enable_i       = 1'b1;
        step(30);
        check_eq("bp_req_cnt",      64'(req_addr_q.size()), 64'd4);
        check_eq("bp_rd3_addr",     64'(q_addr(3)), 64'h1018);
        check_eq("bp_valid_low",    64'(reg_req_o.valid), 64'd0);
        check_eq("bp_busy",         64'(busy_o), 64'd1);
        check_eq("bp_head_idx",     64'(sample_idx_o), 64'd0);
        sample_ready_i = 1'b1;
        step(1);
        sample_ready_i = 1'b0;
        step(20);
        check_eq("bp_req_cnt2",     64'(req_addr_q.size()), 64'd5);
        check_eq("bp_busy2",        64'(busy_o), 64'd1);
        check_eq("bp_head_idx2",    64'(sample_idx_o), 64'd1);
        check_eq("bp_pop_cnt",      64'(smp_q.size()), 64'd1);

        // ---- overrun: period 2, latency 3, full mask ----
        do_reset();
        period_i       = 32'd2;
        counter_mask_i = 16'hFFFF;
        rsp_lat        = 3;
        sample_ready_i = 1'b1;
        enable_i       = 1'b1;
        step(11);
        check_eq("ovr_early",       64'(overrun_cnt_o), 64'd5);
        step(70);
        check_eq("ovr_scan_end",    64'(overrun_cnt_o), 64'd40);
        check_eq("ovr_req_cnt",     64'(req_addr_q.size()), 64'd16);

        // ---- overrun saturation: stalled responder, tick every cycle ----
        do_reset();
        period_i       = 32'd0;
        counter_mask_i = 16'hFFFF;
        rsp_stall      = 1'b1;
        enable_i       = 1'b1;
        step(65535);
        check_eq("sat_fffe",        64'(overrun_cnt_o), 64'hFFFE);
        step(1);
        check_eq("sat_ffff",        64'(overrun_cnt_o), 64'hFFFF);
        step(10);
        check_eq("sat_sticky",      64'(overrun_cnt_o), 64'hFFFF);
        check_eq("sat_req_held",    64'(reg_req_o.valid), 64'd1);

        // ---- error response on idx 3 ----
        do_reset();
        period_i       = 32'd1000;
        counter_mask_i = 16'h0018;
        rsp_err_idx    = 3;
        rsp_rdata      = 64'h0000_AAAA_BBBB_CCCC;
        sample_ready_i = 1'b1;
        enable_i       = 1'b1;
        step(12);
        check_eq("err_smp_cnt",     64'(smp_q.size()), 64'd2);
        check_eq("err_smp0",        64'(q_smp(0)), 64'({48'hAAAA_BBBB_CCCC, 4'd3, 1'b1}));
        check_eq("err_smp1",        64'(q_smp(1)), 64'({48'hAAAA_BBBB_CCCC, 4'd4, 1'b0}));

        // ---- empty mask, tick every cycle ----
        do_reset();
        period_i       = 32'd0;
        counter_mask_i = 16'h0000;
        enable_i       = 1'b1;
        step(11);
        check_eq("empty_overrun5",  64'(overrun_cnt_o), 64'd5);
        check_eq("empty_busy_hi",   64'(busy_o), 64'd1);
        step(1);
        check_eq("empty_busy_lo",   64'(busy_o), 64'd0);
        check_eq("empty_overrun6",  64'(overrun_cnt_o), 64'd6);
        check_eq("empty_no_req",    64'(req_addr_q.size()), 64'd0);

        // ---- disable while a request is stalled ----
        do_reset();
        period_i       = 32'd1000;
        counter_mask_i = 16'h0006;
        rsp_stall      = 1'b1;
        enable_i       = 1'b1;
        step(5);
        check_eq("dis_valid",       64'(reg_req_o.valid), 64'd1);
        check_eq("dis_addr",        64'(reg_req_o.addr),  64'h1008);
        enable_i = 1'b0;
        step(3);
        check_eq("dis_valid_held",  64'(reg_req_o.valid), 64'd1);
        check_eq("dis_addr_held",   64'(reg_req_o.addr),  64'h1008);
        check_eq("dis_busy_held",   64'(busy_o), 64'd1);
        rsp_stall = 1'b0;
        step(3);
        check_eq("dis_valid_done",  64'(reg_req_o.valid), 64'd0);
        check_eq("dis_busy_done",   64'(busy_o), 64'd0);
        check_eq("dis_smp_valid",   64'(sample_valid_o), 64'd1);
        check_eq("dis_smp_idx",     64'(sample_idx_o), 64'd1);
        step(10);
        check_eq("dis_req_cnt",     64'(req_addr_q.size()), 64'd1);
        check_eq("dis_idle_valid",  64'(reg_req_o.valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
